// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle 8-bit CPU control path.
// State enum, opcode map, ALU operation codes and ALU B-operand selects.
package cpu_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        EXEC_R  = 4'd3,
        MEM_RD  = 4'd4,
        MEM_WR  = 4'd5,
        BR_CMP  = 4'd6,
        BR_SKIP = 4'd7,
        JUMP    = 4'd8
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_LD  = 3'b100;
    localparam logic [2:0] OP_ST  = 3'b101;
    localparam logic [2:0] OP_BEQ = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    localparam logic [1:0] SRCB_RS  = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_TWO = 2'b10;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational Moore decoder from control state to datapath controls.
// Register enables in memory states only fire in the cycle the memory completes.
module alu_ctrl_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [2:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic       result_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_control,
    output logic       busy
);

    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        reg_write   = 1'b0;
        result_src  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_RS;
        alu_control = ALU_ADD;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                busy        = 1'b0;
                alu_control = ALU_AND;
            end
            // PC+1 is computed while the instruction is read.
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_ONE;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            EXEC_R: begin
                alu_src_a   = 1'b1;
                alu_control = op[1:0];
                reg_write   = 1'b1;
            end
            MEM_RD: begin
                mem_req    = 1'b1;
                adr_src    = 1'b1;
                result_src = 1'b1;
                reg_write  = mem_ready;
            end
            MEM_WR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            BR_CMP: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
            end
            BR_SKIP: begin
                alu_src_b = SRCB_ONE;
                pc_write  = 1'b1;
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle main control unit: fetch/decode/execute sequencing, ALU control
// generation, memory handshake and retired-instruction counting.
module alu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Run,
    input  logic [7:0]       Instr,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             ResultSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUControl,
    output logic             Busy,
    output logic [CNT_W-1:0] InstrCount,
    output logic [3:0]       dbg_state
);

    // Handshake: MemReq with AdrSrc/MemWrite is held stable from entry into a
    // memory state until the cycle MemReady=1; MemReady is ignored otherwise.
    state_t     state;
    state_t     state_next;
    logic [2:0] op;
    logic       retire;
    logic       unused_instr_bits;

    assign op                = Instr[7:5];
    assign unused_instr_bits = ^Instr[3:0];
    assign dbg_state         = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Run) state_next = FETCH;
            FETCH:   if (MemReady) state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LD:   state_next = MEM_RD;
                    OP_ST:   state_next = MEM_WR;
                    OP_BEQ:  state_next = BR_CMP;
                    OP_JMP:  state_next = Instr[4] ? IDLE : JUMP;
                    default: state_next = EXEC_R;
                endcase
            end
            EXEC_R:  state_next = FETCH;
            MEM_RD:  if (MemReady) state_next = FETCH;
            MEM_WR:  if (MemReady) state_next = FETCH;
            BR_CMP:  state_next = Zero ? BR_SKIP : FETCH;
            BR_SKIP: state_next = FETCH;
            JUMP:    state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    // An instruction retires when control returns to FETCH/IDLE from any state
    // after FETCH; this includes HALT leaving DECODE.
    assign retire = (state_next == FETCH || state_next == IDLE) &&
                    (state != IDLE) && (state != FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      InstrCount <= '0;
        else if (retire) InstrCount <= InstrCount + CNT_W'(1);
    end

    alu_ctrl_decode u_decode (
        .state       (state),
        .op          (op),
        .mem_ready   (MemReady),
        .mem_req     (MemReq),
        .mem_write   (MemWrite),
        .adr_src     (AdrSrc),
        .ir_write    (IRWrite),
        .pc_write    (PCWrite),
        .pc_src      (PCSrc),
        .reg_write   (RegWrite),
        .result_src  (ResultSrc),
        .alu_src_a   (ALUSrcA),
        .alu_src_b   (ALUSrcB),
        .alu_control (ALUControl),
        .busy        (Busy)
    );

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Bench for alu_ctrl_fsm: per-instruction expected output traces built from the
// instruction timing rules, compared cycle by cycle; a CNT_W=4 copy checks wrap.
module tb_alu_ctrl_fsm;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Run = 1'b0;
    logic [7:0]  Instr = 8'h00;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b0;

    logic        MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, PCSrc;
    logic        RegWrite, ResultSrc, ALUSrcA, Busy;
    logic [1:0]  ALUSrcB, ALUControl;
    logic [15:0] InstrCount;
    logic [3:0]  dbg_state;

    logic        w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write, w_pc_src;
    logic        w_reg_write, w_result_src, w_alu_src_a, w_busy;
    logic [1:0]  w_alu_src_b, w_alu_control;
    logic [3:0]  w_count;
    logic [3:0]  w_dbg_state;

    logic [13:0] obs;
    logic [13:0] exp_q[$];
    logic        mr_q[$];
    logic        z_q[$];
    logic [15:0] count_model = 16'd0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    alu_ctrl_fsm u_dut (
        .clk(clk), .rst_n(rst_n), .Run(Run), .Instr(Instr), .Zero(Zero),
        .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .Busy(Busy), .InstrCount(InstrCount),
        .dbg_state(dbg_state)
    );

    alu_ctrl_fsm #(.CNT_W(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .Run(Run), .Instr(Instr), .Zero(Zero),
        .MemReady(MemReady), .MemReq(w_mem_req), .MemWrite(w_mem_write),
        .AdrSrc(w_adr_src), .IRWrite(w_ir_write), .PCWrite(w_pc_write),
        .PCSrc(w_pc_src), .RegWrite(w_reg_write), .ResultSrc(w_result_src),
        .ALUSrcA(w_alu_src_a), .ALUSrcB(w_alu_src_b), .ALUControl(w_alu_control),
        .Busy(w_busy), .InstrCount(w_count), .dbg_state(w_dbg_state)
    );

    assign obs = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, PCSrc, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, Busy};

    function automatic logic [13:0] vec(input logic mreq, mwr, adr, irw, pcw, pcs,
                                        rw, rs, asa, input logic [1:0] asb, alu,
                                        input logic busy);
        return {mreq, mwr, adr, irw, pcw, pcs, rw, rs, asa, asb, alu, busy};
    endfunction

    task automatic check_bit(input string tag, input logic o, input logic e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    // One clock: apply inputs, compare at the falling edge, return at posedge+1.
    task automatic cycle(input logic run, input logic mr, input logic z,
                         input logic [13:0] e, input string tag);
        Run = run;
        MemReady = mr;
        Zero = z;
        @(negedge clk);
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
        tests++;
        assert (InstrCount === count_model) else begin
            fails++;
            $error("FAIL %s_count observed=%h expected=%h", tag, InstrCount, count_model);
        end
        tests++;
        assert (w_count === count_model[3:0]) else begin
            fails++;
            $error("FAIL %s_wrap observed=%h expected=%h", tag, w_count, count_model[3:0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 14'h0, tag);
    endtask

    task automatic start();
        cycle(1'b1, 1'b0, 1'b0, 14'h0, "idle_run");
    endtask

    // Build the expected trace of one instruction from its timing rules, play it.
    task automatic run_instr(input logic [7:0] ins, input int fw, input int mw,
                             input logic z);
        logic [2:0] op;
        logic       rnd;
        op = ins[7:5];
        Instr = ins;
        exp_q.delete(); mr_q.delete(); z_q.delete();
        for (int i = 0; i < fw; i++) begin
            exp_q.push_back(vec(1,0,0,0,0,0,0,0,0,2'b01,2'b10,1)); mr_q.push_back(1'b0);
            z_q.push_back(1'($urandom_range(0, 1)));
        end
        exp_q.push_back(vec(1,0,0,1,1,0,0,0,0,2'b01,2'b10,1)); mr_q.push_back(1'b1);
        z_q.push_back(1'($urandom_range(0, 1)));
        rnd = 1'($urandom_range(0, 1));
        exp_q.push_back(vec(0,0,0,0,0,0,0,0,0,2'b00,2'b10,1)); mr_q.push_back(rnd);
        z_q.push_back(1'($urandom_range(0, 1)));
        if (op[2] == 1'b0) begin
            exp_q.push_back(vec(0,0,0,0,0,0,1,0,1,2'b00,op[1:0],1));
            mr_q.push_back(1'($urandom_range(0, 1))); z_q.push_back(1'($urandom_range(0, 1)));
        end else if (op == 3'b100 || op == 3'b101) begin
            for (int i = 0; i <= mw; i++) begin
                if (op == 3'b100)
                    exp_q.push_back(vec(1,0,1,0,0,0,(i == mw),1,0,2'b00,2'b10,1));
                else
                    exp_q.push_back(vec(1,1,1,0,0,0,0,0,0,2'b00,2'b10,1));
                mr_q.push_back(i == mw);
                z_q.push_back(1'($urandom_range(0, 1)));
            end
        end else if (op == 3'b110) begin
            exp_q.push_back(vec(0,0,0,0,0,0,0,0,1,2'b00,2'b11,1));
            mr_q.push_back(1'($urandom_range(0, 1))); z_q.push_back(z);
            if (z) begin
                exp_q.push_back(vec(0,0,0,0,1,0,0,0,0,2'b01,2'b10,1));
                mr_q.push_back(1'($urandom_range(0, 1))); z_q.push_back(1'($urandom_range(0, 1)));
            end
        end else if (!ins[4]) begin
            exp_q.push_back(vec(0,0,0,0,1,1,0,0,0,2'b00,2'b10,1));
            mr_q.push_back(1'($urandom_range(0, 1))); z_q.push_back(1'($urandom_range(0, 1)));
        end
        while (exp_q.size() > 0)
            cycle(1'($urandom_range(0, 1)), mr_q.pop_front(), z_q.pop_front(),
                  exp_q.pop_front(), $sformatf("op%0d", op));
        count_model = count_model + 16'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ins;
        logic [2:0] op;
        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_memreq", MemReq, 1'b0);
        check_bit("reset_busy", Busy, 1'b0);
        rst_n = 1'b1;
        idle_cycles(10, "idle");

        start();
        run_instr(8'b010_0_01_10, 0, 0, 1'b0);
        run_instr(8'b100_0_10_11, 1, 3, 1'b0);
        run_instr(8'b110_0_01_01, 0, 0, 1'b1);
        run_instr(8'b110_0_01_01, 2, 0, 1'b0);
        run_instr(8'b101_0_11_00, 0, 2, 1'b0);
        run_instr(8'b111_0_00_10, 0, 0, 1'b0);
        run_instr(8'b000_0_01_10, 0, 0, 1'b0);
        run_instr(8'b001_0_11_10, 1, 0, 1'b1);
        run_instr(8'b011_1_00_01, 0, 0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(0, 7));
            ins = {op, 1'b0, 4'($urandom_range(0, 15))};
            if (op != 3'b111) ins[4] = 1'($urandom_range(0, 1));
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)));
        end
        run_instr(8'b111_1_00_00, 0, 0, 1'b0);
        idle_cycles(3, "halt_idle");

        // Reset while a store is waiting on memory.
        start();
        Instr = 8'b101_0_01_10;
        cycle(1'b0, 1'b1, 1'b0, vec(1,0,0,1,1,0,0,0,0,2'b01,2'b10,1), "st_fetch");
        cycle(1'b0, 1'b0, 1'b0, vec(0,0,0,0,0,0,0,0,0,2'b00,2'b10,1), "st_decode");
        cycle(1'b0, 1'b0, 1'b0, vec(1,1,1,0,0,0,0,0,0,2'b00,2'b10,1), "st_wait");
        check_bit("st_hold_memreq", MemReq, 1'b1);
        check_bit("st_hold_memwrite", MemWrite, 1'b1);
        rst_n = 1'b0;
        #1;
        check_bit("rst_memreq", MemReq, 1'b0);
        check_bit("rst_memwrite", MemWrite, 1'b0);
        check_bit("rst_busy", Busy, 1'b0);
        check_bit("rst_count_zero", (InstrCount == 16'd0), 1'b1);
        check_bit("rst_state_idle", (dbg_state == 4'(IDLE)), 1'b1);
        count_model = 16'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(2, "post_rst_idle");
        start();
        run_instr(8'b010_0_00_01, 0, 0, 1'b0);
        run_instr(8'b111_1_00_00, 0, 0, 1'b0);
        idle_cycles(2, "final_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
Multi-cycle main control unit for the 8-bit CPU datapath. It sequences fetch, decode and execute, and drives the ALU's 2-bit ALUControl and select lines. It consumes the ALU's Zero flag for branches and handshakes with a single-port instruction/data memory. It is the producer side of the ALU control interface: it generates ALUControl and consumes Zero.

Parameters:
CNT_W, 16, width of the retired-instruction counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
Run  input  1  leave IDLE and start fetching
Instr  input  8  current IR contents: [7:5] op, [4] H bit, [3:2] rd, [1:0] rs
Zero  input  1  ALU zero flag, combinational from the current ALU operation
MemReady  input  1  memory completes the pending transfer this cycle
MemReq  output  1  memory access request
MemWrite  output  1  write qualifier for MemReq
AdrSrc  output  1  memory address: 0=PC, 1=R[rs]
IRWrite  output  1  load IR from memory read data
PCWrite  output  1  load PC
PCSrc  output  1  PC source: 0=ALUResult, 1=R[rs]
RegWrite  output  1  write R[rd]
ResultSrc  output  1  register write data: 0=ALUResult, 1=memory read data
ALUSrcA  output  1  0=PC, 1=R[rd]
ALUSrcB  output  2  00=R[rs], 01=const 1, 10=const 2, 11=reserved (never driven)
ALUControl  output  2  00 AND, 01 OR, 10 ADD, 11 SUB
Busy  output  1  high in every state except IDLE
InstrCount  output  CNT_W  count of retired instructions

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, InstrCount=0. All outputs are 0 while in IDLE.
- Outputs are Moore, decoded from state only. Register-enable outputs (IRWrite, PCWrite, RegWrite) are additionally ANDed with MemReady in memory states.
- States and transitions:
  - IDLE: Busy=0. Run=1 -> FETCH.
  - FETCH: MemReq=1, AdrSrc=0, ALUSrcA=0, ALUSrcB=01, ALUControl=10.
    - Hold while MemReady=0.
    - On MemReady=1: IRWrite=1 and PCWrite=1 (PC+1) in that same cycle, then -> DECODE.
  - DECODE: one cycle, no enables. Op dispatch:
    - op 0xx -> EXEC_R.
    - 100 -> MEM_RD.
    - 101 -> MEM_WR.
    - 110 -> BR_CMP.
    - 111 with H=0 -> JUMP.
    - 111 with H=1 -> retire, -> IDLE.
  - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUControl=op[1:0], RegWrite=1, ResultSrc=0. -> FETCH.
  - MEM_RD: MemReq=1, AdrSrc=1. On MemReady: RegWrite=1, ResultSrc=1, -> FETCH; otherwise hold.
  - MEM_WR: MemReq=1, MemWrite=1, AdrSrc=1. On MemReady -> FETCH; otherwise hold.
  - BR_CMP: ALUSrcA=1, ALUSrcB=00, ALUControl=11.
    - Zero=1 -> BR_SKIP.
    - Zero=0 -> FETCH.
  - BR_SKIP: ALUSrcA=0, ALUSrcB=01, ALUControl=10, PCWrite=1 (skips one instruction). -> FETCH.
  - JUMP: PCWrite=1, PCSrc=1. -> FETCH.
- Handshake:
  - MemReq stays high and all address/write qualifiers stay stable until the cycle MemReady=1.
  - MemReady while MemReq=0 is ignored.
  - There is no timeout.
- InstrCount increments by 1 on every transition into FETCH or IDLE from a post-DECODE state, so HALT counts. It wraps to 0 after all-ones.
- Run is only sampled in IDLE. Deasserting Run mid-program has no effect.
- rst_n asserted mid-transfer drops MemReq immediately, with no completion.
- Latency: ALU op 3 cycles, BEQ-taken 4 cycles, LD/ST 3 cycles plus memory wait. Each memory state adds one cycle per MemReady=0 cycle.
- Unused output encodings: ALUSrcB=11 is never produced.
- In states that do not use the ALU, ALUControl=10 and the ALU selects are 0.

Decomposition:
- Package cpu_pkg holds:
  - enum state_t (IDLE, FETCH, DECODE, EXEC_R, MEM_RD, MEM_WR, BR_CMP, BR_SKIP, JUMP).
  - Opcode constants (OP_AND..OP_SUB, OP_LD, OP_ST, OP_BEQ, OP_JMP).
  - ALUControl localparams ALU_AND/OR/ADD/SUB.
  - ALUSrcB encodings.
- One natural sub-module: alu_ctrl_decode, a combinational state-to-output decoder. State register, next-state logic and counter stay in the top.

Test Plan:
- Reset then Run=0 for 10 cycles -> Busy=0, all outputs 0, InstrCount=0. Run=1 -> next cycle FETCH, MemReq=1, AdrSrc=0.
- Instr=8'b010_0_01_10 (ADD) with MemReady=1 in FETCH -> IRWrite, PCWrite, ALUControl=10. Two cycles later: RegWrite=1, ALUControl=10, ALUSrcB=00. InstrCount=1.
- LD (Instr=8'b100_0_10_11) with MemReady low for 3 cycles in MEM_RD -> MemReq held and RegWrite=0 for 3 cycles, then RegWrite=1 and ResultSrc=1 in the ready cycle.
- BEQ with Zero=1 -> BR_CMP ALUControl=11, then BR_SKIP PCWrite=1 with ALUSrcB=01. Same instruction with Zero=0 -> straight to FETCH, no extra PCWrite.
- HALT (Instr=8'b111_1_00_00) -> back to IDLE, Busy=0, InstrCount incremented. Separately: preload the counter path to 16'hFFFF and retire one instruction -> InstrCount=0.
- Assert rst_n=0 while MEM_WR is waiting -> MemReq and MemWrite drop asynchronously. After release, state=IDLE and InstrCount=0.
